// File: rtl/list_engine.sv
// Ordered element list with insert/delete/search/reduce/sort operations.
// Every operation runs IDLE -> EXEC (one or more cycles) -> IDLE with a registered op_done pulse.
module list_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LENGTH     = 8,
    parameter int unsigned SUM_METHOD = 0,
    localparam int unsigned LENGTH_WIDTH = $clog2(LENGTH),
    localparam int unsigned OUT_WIDTH    = DATA_WIDTH + LENGTH_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              op_sel,
    input  logic                    op_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [LENGTH_WIDTH-1:0] index_in,
    output logic [OUT_WIDTH-1:0]    data_out,
    output logic                    op_done,
    output logic                    op_in_progress,
    output logic                    op_error,
    output logic [LENGTH_WIDTH:0]   count_out,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned CW = LENGTH_WIDTH + 1;

    localparam logic [3:0] OpRead    = 4'd0;
    localparam logic [3:0] OpInsert  = 4'd1;
    localparam logic [3:0] OpDelete  = 4'd2;
    localparam logic [3:0] OpFind    = 4'd3;
    localparam logic [3:0] OpCount   = 4'd4;
    localparam logic [3:0] OpSum     = 4'd5;
    localparam logic [3:0] OpSortAsc = 4'd6;
    localparam logic [3:0] OpSortDes = 4'd7;
    localparam logic [3:0] OpMin     = 4'd8;
    localparam logic [3:0] OpMax     = 4'd9;
    localparam logic [3:0] OpClear   = 4'd10;

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e                  state_q;
    logic [3:0]              op_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [LENGTH_WIDTH-1:0] idx_q;
    logic [CW-1:0]           cyc_q;
    logic [OUT_WIDTH-1:0]    acc_q;
    logic [DATA_WIDTH-1:0]   elem_q [LENGTH];

    logic [DATA_WIDTH-1:0]   elem_d [LENGTH];
    logic [CW-1:0]           count_d;
    logic [OUT_WIDTH-1:0]    acc_d, res, sum_all, ext_cur, pick;
    logic [CW-1:0]           pos, idx_ext;
    logic [DATA_WIDTH-1:0]   cur;
    logic                    fin, err, wr_out, last, idx_oor;

    always_comb begin
        sum_all = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (CW'(i) < count_out) sum_all = sum_all + OUT_WIDTH'(elem_q[i]);
        end
    end

    always_comb begin
        elem_d  = elem_q;
        count_d = count_out;
        acc_d   = acc_q;
        fin     = 1'b1;
        err     = 1'b0;
        wr_out  = 1'b0;
        res     = data_out;
        cur     = elem_q[cyc_q[LENGTH_WIDTH-1:0]];
        ext_cur = OUT_WIDTH'(cur);
        idx_ext = {1'b0, idx_q};
        idx_oor = idx_ext >= count_out;
        pos     = idx_oor ? count_out : idx_ext;
        last    = (count_out == '0) || (cyc_q == count_out - 1'b1);
        pick    = ((cyc_q == '0) || ((op_q == OpMin) ? (ext_cur < acc_q) : (ext_cur > acc_q)))
                  ? ext_cur : acc_q;
        case (op_q)
            OpRead: begin
                if (idx_oor) begin
                    err = 1'b1;
                end else begin
                    wr_out = 1'b1;
                    res    = OUT_WIDTH'(elem_q[idx_q]);
                end
            end
            OpInsert: begin
                if (count_out == CW'(LENGTH)) begin
                    err = 1'b1;
                end else begin
                    for (int i = 1; i < LENGTH; i++) begin
                        if (CW'(i) > pos && CW'(i) <= count_out) elem_d[i] = elem_q[i-1];
                    end
                    for (int i = 0; i < LENGTH; i++) begin
                        if (CW'(i) == pos) elem_d[i] = data_q;
                    end
                    count_d = count_out + 1'b1;
                end
            end
            OpDelete: begin
                if (idx_oor) begin
                    err = 1'b1;
                end else begin
                    for (int i = 0; i < LENGTH - 1; i++) begin
                        if (CW'(i) >= idx_ext) elem_d[i] = elem_q[i+1];
                    end
                    count_d = count_out - 1'b1;
                end
            end
            OpFind: begin
                fin = 1'b0;
                if (count_out == '0) begin
                    fin = 1'b1;
                    err = 1'b1;
                end else if (cur == data_q) begin
                    fin    = 1'b1;
                    wr_out = 1'b1;
                    res    = OUT_WIDTH'(cyc_q);
                end else if (last) begin
                    fin = 1'b1;
                    err = 1'b1;
                end
            end
            OpCount: begin
                acc_d  = acc_q + OUT_WIDTH'((count_out != '0) && (cur == data_q));
                fin    = last;
                wr_out = 1'b1;
                res    = acc_d;
            end
            OpSum: begin
                wr_out = 1'b1;
                if (SUM_METHOD == 0) begin
                    res = sum_all;
                end else begin
                    acc_d = acc_q + ((count_out != '0) ? ext_cur : '0);
                    fin   = last;
                    res   = acc_d;
                end
            end
            OpSortAsc, OpSortDes: begin
                // Even phases compare (0,1),(2,3)...; odd phases (1,2),(3,4)...
                // Swapping only on strict inequality keeps equal values in order.
                fin = (cyc_q == CW'(LENGTH - 1));
                for (int j = 0; j < LENGTH - 1; j++) begin
                    if (((j % 2) == 1) == cyc_q[0] && CW'(j + 1) < count_out) begin
                        if ((op_q == OpSortAsc) ? (elem_q[j] > elem_q[j+1])
                                                : (elem_q[j] < elem_q[j+1])) begin
                            elem_d[j]   = elem_q[j+1];
                            elem_d[j+1] = elem_q[j];
                        end
                    end
                end
            end
            OpMin, OpMax: begin
                if (count_out == '0) begin
                    err = 1'b1;
                end else begin
                    acc_d  = pick;
                    fin    = last;
                    wr_out = 1'b1;
                    res    = pick;
                end
            end
            OpClear: count_d = '0;
            default: err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            op_q           <= '0;
            data_q         <= '0;
            idx_q          <= '0;
            cyc_q          <= '0;
            acc_q          <= '0;
            for (int i = 0; i < LENGTH; i++) elem_q[i] <= '0;
            data_out       <= '0;
            op_done        <= 1'b0;
            op_in_progress <= 1'b0;
            op_error       <= 1'b0;
            count_out      <= '0;
            full           <= 1'b0;
            empty          <= 1'b1;
        end else begin
            op_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (op_en) begin
                        op_q           <= op_sel;
                        data_q         <= data_in;
                        idx_q          <= index_in;
                        cyc_q          <= '0;
                        acc_q          <= '0;
                        state_q        <= StExec;
                        op_in_progress <= 1'b1;
                    end
                end
                StExec: begin
                    elem_q <= elem_d;
                    acc_q  <= acc_d;
                    cyc_q  <= cyc_q + 1'b1;
                    if (fin) begin
                        state_q        <= StIdle;
                        op_in_progress <= 1'b0;
                        op_done        <= 1'b1;
                        op_error       <= err;
                        if (wr_out) data_out <= res;
                        count_out      <= count_d;
                        full           <= (count_d == CW'(LENGTH));
                        empty          <= (count_d == '0);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_list_engine.sv
// Directed bench for list_engine: two instances share stimulus, differing only in SUM_METHOD.
module tb_list_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  op_sel;
    logic        op_en;
    logic [7:0]  data_in;
    logic [2:0]  index_in;

    logic [10:0] dout0, dout1;
    logic        done0, done1, busy0, busy1, err0, err1;
    logic        full0, full1, empty0, empty1;
    logic [3:0]  cnt0, cnt1;

    int total = 0;
    int bad   = 0;
    int lat0, lat1;

    list_engine #(.DATA_WIDTH(8), .LENGTH(8), .SUM_METHOD(0)) u_dut0 (
        .clk(clk), .rst(rst), .op_sel(op_sel), .op_en(op_en), .data_in(data_in),
        .index_in(index_in), .data_out(dout0), .op_done(done0), .op_in_progress(busy0),
        .op_error(err0), .count_out(cnt0), .full(full0), .empty(empty0)
    );

    list_engine #(.DATA_WIDTH(8), .LENGTH(8), .SUM_METHOD(1)) u_dut1 (
        .clk(clk), .rst(rst), .op_sel(op_sel), .op_en(op_en), .data_in(data_in),
        .index_in(index_in), .data_out(dout1), .op_done(done1), .op_in_progress(busy1),
        .op_error(err1), .count_out(cnt1), .full(full1), .empty(empty1)
    );

    always #5 clk = ~clk;

    // Issues one op and waits (bounded) until both instances have pulsed op_done.
    task automatic do_op(input logic [3:0] op, input logic [7:0] d, input logic [2:0] idx);
        int n;
        bit s0, s1;
        @(negedge clk);
        op_sel = op; data_in = d; index_in = idx; op_en = 1'b1;
        @(negedge clk);
        op_en = 1'b0;
        n = 0; s0 = 0; s1 = 0; lat0 = 0; lat1 = 0;
        while (!(s0 && s1) && n < 100) begin
            n++;
            @(negedge clk);
            if (!s0 && done0) begin s0 = 1; lat0 = n; end
            if (!s1 && done1) begin s1 = 1; lat1 = n; end
        end
        total++;
        if (!(s0 && s1)) begin
            bad++;
            $display("FAIL op_timeout op=%0d: done0=%0b done1=%0b required both", op, s0, s1);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0; op_en = 1'b0; op_sel = '0; data_in = '0; index_in = '0;
        repeat (2) @(negedge clk);
        total++;
        if (dout0 !== 11'd0 || cnt0 !== 4'd0 || done0 !== 1'b0 || busy0 !== 1'b0 ||
            err0 !== 1'b0 || full0 !== 1'b0 || empty0 !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: dout=%0d cnt=%0d done=%0b busy=%0b err=%0b full=%0b empty=%0b required 0 0 0 0 0 0 1",
                     dout0, cnt0, done0, busy0, err0, full0, empty0);
        end
        // Op presented together with reset release must be taken on the first edge.
        @(negedge clk);
        rst = 1'b1; op_sel = 4'd1; data_in = 8'd5; index_in = 3'd7; op_en = 1'b1;
        @(negedge clk);
        op_en = 1'b0;
        total++;
        if (busy0 !== 1'b1) begin
            bad++;
            $display("FAIL first_edge_accept: busy=%0b required 1", busy0);
        end
        n = 0;
        while (!done0 && n < 20) begin n++; @(negedge clk); end
        total++;
        if (cnt0 !== 4'd1 || err0 !== 1'b0) begin
            bad++;
            $display("FAIL first_insert: cnt=%0d err=%0b required 1 0", cnt0, err0);
        end
    endtask

    task automatic test_insert_read();
        logic [10:0] exp [3];
        exp[0] = 11'd3; exp[1] = 11'd7; exp[2] = 11'd5;
        do_op(4'd1, 8'd3, 3'd0);
        do_op(4'd1, 8'd7, 3'd1);
        total++;
        if (cnt0 !== 4'd3) begin
            bad++; $display("FAIL insert_count: cnt=%0d required 3", cnt0);
        end
        for (int i = 0; i < 3; i++) begin
            do_op(4'd0, 8'd0, 3'(i));
            total++;
            if (dout0 !== exp[i] || err0 !== 1'b0 || lat0 !== 1) begin
                bad++;
                $display("FAIL read_%0d: data=%0d err=%0b lat=%0d required %0d 0 1",
                         i, dout0, err0, lat0, exp[i]);
            end
        end
        do_op(4'd0, 8'd0, 3'd3);
        total++;
        if (err0 !== 1'b1 || dout0 !== 11'd5) begin
            bad++; $display("FAIL read_oor: err=%0b data=%0d required 1 5", err0, dout0);
        end
    endtask

    task automatic test_full();
        do_op(4'd10, 8'd0, 3'd0);
        for (int i = 0; i < 8; i++) do_op(4'd1, 8'(10 + i), 3'd7);
        total++;
        if (full0 !== 1'b1 || cnt0 !== 4'd8 || empty0 !== 1'b0) begin
            bad++; $display("FAIL fill: full=%0b cnt=%0d empty=%0b required 1 8 0", full0, cnt0, empty0);
        end
        do_op(4'd1, 8'd99, 3'd0);
        total++;
        if (err0 !== 1'b1 || full0 !== 1'b1 || cnt0 !== 4'd8) begin
            bad++; $display("FAIL insert_full: err=%0b full=%0b cnt=%0d required 1 1 8", err0, full0, cnt0);
        end
        do_op(4'd0, 8'd0, 3'd0);
        total++;
        if (dout0 !== 11'd10) begin
            bad++; $display("FAIL full_unchanged: data=%0d required 10", dout0);
        end
        do_op(4'd2, 8'd0, 3'd0);
        total++;
        if (err0 !== 1'b0 || full0 !== 1'b0 || cnt0 !== 4'd7) begin
            bad++; $display("FAIL delete_0: err=%0b full=%0b cnt=%0d required 0 0 7", err0, full0, cnt0);
        end
        do_op(4'd2, 8'd0, 3'd3);
        do_op(4'd0, 8'd0, 3'd3);
        total++;
        if (dout0 !== 11'd15 || cnt0 !== 4'd6) begin
            bad++; $display("FAIL delete_mid: data=%0d cnt=%0d required 15 6", dout0, cnt0);
        end
        do_op(4'd2, 8'd0, 3'd6);
        total++;
        if (err0 !== 1'b1 || cnt0 !== 4'd6) begin
            bad++; $display("FAIL delete_oor: err=%0b cnt=%0d required 1 6", err0, cnt0);
        end
    endtask

    task automatic test_scan();
        do_op(4'd10, 8'd0, 3'd0);
        do_op(4'd1, 8'd4, 3'd7);
        do_op(4'd1, 8'd2, 3'd7);
        do_op(4'd1, 8'd4, 3'd7);
        do_op(4'd1, 8'd1, 3'd7);
        do_op(4'd3, 8'd4, 3'd0);
        total++;
        if (dout0 !== 11'd0 || err0 !== 1'b0 || lat0 !== 1) begin
            bad++; $display("FAIL find_4: data=%0d err=%0b lat=%0d required 0 0 1", dout0, err0, lat0);
        end
        do_op(4'd3, 8'd1, 3'd0);
        total++;
        if (dout0 !== 11'd3 || err0 !== 1'b0 || lat0 !== 4) begin
            bad++; $display("FAIL find_1: data=%0d err=%0b lat=%0d required 3 0 4", dout0, err0, lat0);
        end
        do_op(4'd4, 8'd4, 3'd0);
        total++;
        if (dout0 !== 11'd2 || err0 !== 1'b0 || lat0 !== 4) begin
            bad++; $display("FAIL count_4: data=%0d err=%0b lat=%0d required 2 0 4", dout0, err0, lat0);
        end
        do_op(4'd3, 8'd6, 3'd0);
        total++;
        if (err0 !== 1'b1 || lat0 !== 4) begin
            bad++; $display("FAIL find_6: err=%0b lat=%0d required 1 4", err0, lat0);
        end
        do_op(4'd8, 8'd0, 3'd0);
        total++;
        if (dout0 !== 11'd1 || err0 !== 1'b0 || lat0 !== 4) begin
            bad++; $display("FAIL min: data=%0d err=%0b lat=%0d required 1 0 4", dout0, err0, lat0);
        end
        do_op(4'd9, 8'd0, 3'd0);
        total++;
        if (dout0 !== 11'd4 || err0 !== 1'b0 || lat0 !== 4) begin
            bad++; $display("FAIL max: data=%0d err=%0b lat=%0d required 4 0 4", dout0, err0, lat0);
        end
        do_op(4'd5, 8'd0, 3'd0);
        total++;
        if (dout0 !== 11'd11 || lat0 !== 1 || dout1 !== 11'd11 || lat1 !== 4) begin
            bad++;
            $display("FAIL sum_small: d0=%0d l0=%0d d1=%0d l1=%0d required 11 1 11 4",
                     dout0, lat0, dout1, lat1);
        end
    endtask

    // Reads indices 0..3 with op_en held; results must arrive every second cycle.
    task automatic burst_read(input logic [3:0][10:0] exp, input string nm);
        int gap;
        @(negedge clk);
        op_sel = 4'd0; index_in = 3'd0; op_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gap = 0;
            do begin @(negedge clk); gap++; end while (!done0 && gap < 20);
            total++;
            if (done0 !== 1'b1 || dout0 !== exp[k] || err0 !== 1'b0 || gap !== 2) begin
                bad++;
                $display("FAIL %s_%0d: done=%0b data=%0d err=%0b gap=%0d required 1 %0d 0 2",
                         nm, k, done0, dout0, err0, gap, exp[k]);
            end
            index_in = 3'(k + 1);
            if (k == 3) op_en = 1'b0;
        end
    endtask

    task automatic test_sort();
        do_op(4'd6, 8'd0, 3'd0);
        total++;
        if (lat0 !== 8 || lat1 !== 8 || err0 !== 1'b0 || cnt0 !== 4'd4) begin
            bad++; $display("FAIL sort_asc_lat: l0=%0d l1=%0d err=%0b cnt=%0d required 8 8 0 4",
                            lat0, lat1, err0, cnt0);
        end
        burst_read({11'd4, 11'd4, 11'd2, 11'd1}, "asc");
        do_op(4'd7, 8'd0, 3'd0);
        total++;
        if (lat0 !== 8 || err0 !== 1'b0) begin
            bad++; $display("FAIL sort_des_lat: lat=%0d err=%0b required 8 0", lat0, err0);
        end
        burst_read({11'd1, 11'd2, 11'd4, 11'd4}, "des");
    endtask

    task automatic test_sum_max();
        do_op(4'd10, 8'd0, 3'd0);
        for (int i = 0; i < 8; i++) do_op(4'd1, 8'd255, 3'd7);
        do_op(4'd5, 8'd0, 3'd0);
        total++;
        if (dout0 !== 11'd2040 || lat0 !== 1 || dout1 !== 11'd2040 || lat1 !== 8) begin
            bad++;
            $display("FAIL sum_max: d0=%0d l0=%0d d1=%0d l1=%0d required 2040 1 2040 8",
                     dout0, lat0, dout1, lat1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op_sel = 4'd6; op_en = 1'b1;
        @(negedge clk);
        op_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (dout0 !== 11'd0 || cnt0 !== 4'd0 || done0 !== 1'b0 || busy0 !== 1'b0 ||
            busy1 !== 1'b0 || err0 !== 1'b0 || full0 !== 1'b0 || empty0 !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_state: dout=%0d cnt=%0d done=%0b busy=%0b/%0b err=%0b full=%0b empty=%0b",
                     dout0, cnt0, done0, busy0, busy1, err0, full0, empty0);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            total++;
            if (done0 !== 1'b0 || done1 !== 1'b0) begin
                bad++; $display("FAIL reset_mid_nodone_%0d: done=%0b/%0b required 0", i, done0, done1);
            end
        end
    endtask

    task automatic test_misc();
        do_op(4'd8, 8'd0, 3'd0);
        total++;
        if (err0 !== 1'b1 || lat0 !== 1) begin
            bad++; $display("FAIL min_empty: err=%0b lat=%0d required 1 1", err0, lat0);
        end
        do_op(4'd3, 8'd0, 3'd0);
        total++;
        if (err0 !== 1'b1 || lat0 !== 1) begin
            bad++; $display("FAIL find_empty: err=%0b lat=%0d required 1 1", err0, lat0);
        end
        do_op(4'd4, 8'd0, 3'd0);
        total++;
        if (err0 !== 1'b0 || dout0 !== 11'd0 || lat0 !== 1) begin
            bad++; $display("FAIL count_empty: err=%0b data=%0d lat=%0d required 0 0 1", err0, dout0, lat0);
        end
        do_op(4'd1, 8'd9, 3'd0);
        do_op(4'd12, 8'd0, 3'd0);
        total++;
        if (err0 !== 1'b1 || lat0 !== 1 || cnt0 !== 4'd1) begin
            bad++; $display("FAIL op12: err=%0b lat=%0d cnt=%0d required 1 1 1", err0, lat0, cnt0);
        end
        do_op(4'd0, 8'd0, 3'd0);
        total++;
        if (dout0 !== 11'd9 || err0 !== 1'b0) begin
            bad++; $display("FAIL op12_unchanged: data=%0d err=%0b required 9 0", dout0, err0);
        end
        do_op(4'd10, 8'd0, 3'd0);
        total++;
        if (empty0 !== 1'b1 || cnt0 !== 4'd0 || err0 !== 1'b0 || lat0 !== 1) begin
            bad++; $display("FAIL clear: empty=%0b cnt=%0d err=%0b lat=%0d required 1 0 0 1",
                            empty0, cnt0, err0, lat0);
        end
        do_op(4'd5, 8'd0, 3'd0);
        total++;
        if (dout0 !== 11'd0 || dout1 !== 11'd0 || lat1 !== 1 || err0 !== 1'b0) begin
            bad++; $display("FAIL sum_empty: d0=%0d d1=%0d l1=%0d err=%0b required 0 0 1 0",
                            dout0, dout1, lat1, err0);
        end
    endtask

    initial begin
        test_reset();
        test_insert_read();
        test_full();
        test_scan();
        test_sort();
        test_sum_max();
        test_reset_mid();
        test_misc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
